// File: rtl/cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : cdc_handshake_tx
// Purpose  : Source side of a 4-phase req/ack handshake. Captures one word,
//            raises a registered request toward the far clock domain, waits
//            for the synchronized acknowledge to rise and fall, then reports
//            completion. An optional timeout aborts a request that never
//            receives an acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_tx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ack_async,
  output logic              done,
  output logic              timeout_err,
  output logic              busy
);

  // Counter only needs to reach TIMEOUT_CYC-1; keep at least one bit so the
  // declaration stays legal when the timeout is disabled.
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   ack_s;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nx;
  logic                   aborted;
  logic                   aborted_nx;
  logic                   req_nx;
  logic [DATA_W-1:0]      data_nx;
  logic                   done_nx;
  logic                   terr_nx;

  // Acknowledge synchronizer; only the last stage is visible to the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], tx_ack_async};
    end
  end

  assign ack_s    = sync[SYNC_STAGES-1];
  // A stale ack left high from a previous transfer blocks new accepts.
  assign in_ready = (state == IDLE) && !ack_s;
  assign busy     = (state != IDLE);

  // Next-state, request/data and pulse computation.
  always_comb begin
    state_nx   = state;
    req_nx     = tx_req;
    data_nx    = tx_data;
    cnt_nx     = cnt;
    aborted_nx = aborted;
    done_nx    = 1'b0;
    terr_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_nx    = in_data;
          req_nx     = 1'b1;
          state_nx   = REQ_HI;
          cnt_nx     = '0;
          aborted_nx = 1'b0;
        end
      end
      REQ_HI: begin
        // The ack takes priority over a timeout reached in the same cycle.
        if (ack_s) begin
          req_nx   = 1'b0;
          state_nx = REQ_LO;
        end else if ((TIMEOUT_CYC > 0) && (cnt == CNT_LAST)) begin
          req_nx     = 1'b0;
          state_nx   = REQ_LO;
          terr_nx    = 1'b1;
          aborted_nx = 1'b1;
        end else if (TIMEOUT_CYC > 0) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      REQ_LO: begin
        // An aborted transfer returns to IDLE silently.
        if (!ack_s) begin
          state_nx = IDLE;
          done_nx  = !aborted;
        end
      end
      default: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_req      <= 1'b0;
      tx_data     <= '0;
      cnt         <= '0;
      aborted     <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      tx_req      <= req_nx;
      tx_data     <= data_nx;
      cnt         <= cnt_nx;
      aborted     <= aborted_nx;
      done        <= done_nx;
      timeout_err <= terr_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdc_handshake_tx
// Purpose  : Directed self-checking bench for cdc_handshake_tx with a
//            one-cycle-delay far-side model and manual ack control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_tx;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          tx_req;
  logic [DW-1:0] tx_data;
  logic          done;
  logic          timeout_err;
  logic          busy;
  logic          ack_async;
  logic          far_auto = 1'b1;
  logic          far_ack = 1'b0;
  logic          manual_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state
  int            ncyc = 0;
  int            done_cnt = 0;
  int            terr_cnt = 0;
  int            stable_err = 0;
  logic          prev_req = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] seen[$];
  int            rise_cyc[$];
  int            done_cyc[$];

  cdc_handshake_tx #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .tx_req       (tx_req),
    .tx_data      (tx_data),
    .tx_ack_async (ack_async),
    .done         (done),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Far side: ack follows req with one cycle of delay.
  always @(posedge clk) far_ack <= tx_req;
  assign ack_async = far_auto ? far_ack : manual_ack;

  // Observe pulses, words seen by the far side and data stability.
  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc.push_back(ncyc);
    end
    if (timeout_err === 1'b1) terr_cnt <= terr_cnt + 1;
    if (tx_req === 1'b1 && prev_req === 1'b0) begin
      seen.push_back(tx_data);
      rise_cyc.push_back(ncyc);
    end
    if (tx_req === 1'b1 && prev_req === 1'b1 && tx_data !== prev_data)
      stable_err <= stable_err + 1;
    prev_req  <= tx_req;
    prev_data <= tx_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (tx_req !== 1'b0) begin n_fail++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++; if (done !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: done %b terr %b want 0 0", done, timeout_err); end
    rst = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    int hi = 0;
    int dk = -1;
    int bad = 0;
    far_auto = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick();
      if (tx_req === 1'b1) begin
        hi++;
        if (tx_data !== 8'hA5) bad++;
      end
      if (done === 1'b1) dk = k;
    end
    n_checks++; if (hi != 4) begin n_fail++; $display("FAIL basic_req_width: got %0d want 4", hi); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_data_during_req: got %0d bad want 0", bad); end
    n_checks++; if (dk != 8) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 8", dk); end
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: in_ready %b busy %b want 1 0", in_ready, busy); end
    n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data_hold: got %h want a5", tx_data); end
  endtask

  task automatic test_back_to_back();
    int sz = seen.size();
    int rs = rise_cyc.size();
    int ds = done_cyc.size();
    int se = stable_err;
    int d0 = done_cnt;
    int nacc = 0;
    logic acc;
    far_auto = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h11;
    for (int k = 0; k < 60 && nacc < 2; k++) begin
      acc = in_valid & in_ready;
      tick();
      if (acc) begin
        nacc++;
        if (nacc == 1) in_data = 8'h22;
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (12) tick();
    n_checks++; if (nacc != 2) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 2", nacc); end
    n_checks++; if (seen.size() - sz != 2) begin n_fail++; $display("FAIL b2b_words: got %0d want 2", seen.size() - sz); end
    else begin
      n_checks++; if (seen[sz] !== 8'h11 || seen[sz+1] !== 8'h22) begin n_fail++; $display("FAIL b2b_order: got %h %h want 11 22", seen[sz], seen[sz+1]); end
    end
    n_checks++; if (stable_err != se) begin n_fail++; $display("FAIL b2b_stable: got %0d changes want 0", stable_err - se); end
    n_checks++; if (done_cnt - d0 != 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
    n_checks++;
    if (rise_cyc.size() < rs + 2 || done_cyc.size() < ds + 1) begin
      n_fail++; $display("FAIL b2b_order_vs_done: missing events rises %0d dones %0d", rise_cyc.size() - rs, done_cyc.size() - ds);
    end else if (rise_cyc[rs+1] <= done_cyc[ds]) begin
      n_fail++; $display("FAIL b2b_order_vs_done: second req at %0d want after done at %0d", rise_cyc[rs+1], done_cyc[ds]);
    end
  endtask

  task automatic test_stale_ack();
    int viol = 0;
    int d0 = done_cnt;
    far_auto   = 1'b0;
    manual_ack = 1'b1;
    repeat (3) tick();
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (in_ready !== 1'b0 || busy !== 1'b0 || tx_req !== 1'b0) viol++;
    end
    n_checks++; if (viol != 0) begin n_fail++; $display("FAIL stale_blocked: got %0d bad cycles want 0", viol); end
    manual_ack = 1'b0;
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stale_ready_1: got %b want 0", in_ready); end
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stale_ready_2: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (tx_req !== 1'b1 || tx_data !== 8'h77) begin n_fail++; $display("FAIL stale_accept: req %b data %h want 1 77", tx_req, tx_data); end
    far_auto = 1'b1;
    repeat (12) tick();
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL stale_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_timeout();
    int d0 = done_cnt;
    int t0 = terr_cnt;
    int hi = 0;
    far_auto   = 1'b0;
    manual_ack = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h5C;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 40 && tx_req === 1'b1; k++) begin
      hi++;
      tick();
    end
    n_checks++; if (hi != TO) begin n_fail++; $display("FAIL timeout_req_cycles: got %0d want %0d", hi, TO); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got %b want 1", timeout_err); end
    n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout_reqlo: in_ready %b busy %b want 0 1", in_ready, busy); end
    tick();
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: in_ready %b busy %b terr %b want 1 0 0", in_ready, busy, timeout_err); end
    repeat (4) tick();
    n_checks++; if (done_cnt - d0 != 0 || terr_cnt - t0 != 1) begin n_fail++; $display("FAIL timeout_counts: done %0d terr %0d want 0 1", done_cnt - d0, terr_cnt - t0); end
  endtask

  task automatic test_collision();
    int d0 = done_cnt;
    int t0 = terr_cnt;
    far_auto   = 1'b0;
    manual_ack = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    in_valid = 1'b0;
    repeat (13) tick();
    manual_ack = 1'b1;
    repeat (2) tick();
    n_checks++; if (tx_req !== 1'b1) begin n_fail++; $display("FAIL collide_req_held: got %b want 1", tx_req); end
    tick();
    n_checks++; if (tx_req !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL collide_edge: req %b terr %b want 0 0", tx_req, timeout_err); end
    manual_ack = 1'b0;
    repeat (3) tick();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL collide_done: got %b want 1", done); end
    repeat (3) tick();
    n_checks++; if (done_cnt - d0 != 1 || terr_cnt - t0 != 0) begin n_fail++; $display("FAIL collide_counts: done %0d terr %0d want 1 0", done_cnt - d0, terr_cnt - t0); end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    int t0 = terr_cnt;
    far_auto = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    n_checks++; if (tx_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_started: req %b busy %b want 1 1", tx_req, busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (tx_req !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: req %b data %h busy %b want 0 00 0", tx_req, tx_data, busy); end
    n_checks++; if (done !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_pulses: done %b terr %b want 0 0", done, timeout_err); end
    repeat (12) tick();
    n_checks++; if (done_cnt - d0 != 0 || terr_cnt - t0 != 0) begin n_fail++; $display("FAIL rstmid_counts: done %0d terr %0d want 0 0", done_cnt - d0, terr_cnt - t0); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    repeat (3) tick();
    test_back_to_back();
    repeat (3) tick();
    test_stale_ack();
    repeat (3) tick();
    test_timeout();
    repeat (3) tick();
    test_collision();
    repeat (3) tick();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/cdc_handshake_tx.md
CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 Parameter DATA_W, default 8, width of the transferred word.
REQ-002 Parameter SYNC_STAGES, default 2, flop count in the ack synchronizer; legal values are 2 or more.
REQ-003 Parameter TIMEOUT_CYC, default 0, maximum cycles to wait for ack high; 0 disables the timeout.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  source word available.
REQ-008 in_ready  out  1  block can accept a word this cycle.
REQ-009 in_data  in  DATA_W  word to transfer, sampled on accept.
REQ-010 tx_req  out  1  4-phase request level to the far domain, registered.
REQ-011 tx_data  out  DATA_W  registered word, stable while a transfer is in flight.
REQ-012 tx_ack_async  in  1  4-phase acknowledge from the far domain, asynchronous to clk.
REQ-013 done  out  1  one-cycle pulse when a transfer completes.
REQ-014 timeout_err  out  1  one-cycle pulse when a timeout aborts a transfer.
REQ-015 busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 tx_ack_async SHALL pass through a SYNC_STAGES flop chain. ack_s is the last stage, and only ack_s SHALL be used by the logic.
REQ-017 The FSM states SHALL be IDLE, REQ_HI and REQ_LO, encoded in registers.
REQ-018 in_ready SHALL be combinational and equal to (state==IDLE) && !ack_s.
REQ-019 Accept occurs when in_valid && in_ready. On accept, tx_data <= in_data, tx_req <= 1 and state <= REQ_HI. tx_req is therefore high one cycle after the accept edge.
REQ-020 In REQ_HI, when ack_s==1, the block SHALL set tx_req <= 0 and state <= REQ_LO.
REQ-021 In REQ_LO, when ack_s==0, the block SHALL set state <= IDLE and pulse done for exactly one cycle, in the cycle after the transition edge.
REQ-022 tx_data SHALL NOT change outside an accept. It holds its value from accept through the return to IDLE and afterwards.
REQ-023 tx_req SHALL change only on the accept and REQ_HI->REQ_LO transitions, except for reset and timeout.
REQ-024 In IDLE with ack_s==1 (stale ack), the block SHALL hold in_ready=0 and accept nothing until ack_s==0.
REQ-025 in_valid SHALL be ignored while in_ready==0. No word is queued or dropped silently; the source holds it.
REQ-026 With TIMEOUT_CYC>0, a counter SHALL clear on entry to REQ_HI and increment each cycle in REQ_HI.
REQ-027 When the counter reaches TIMEOUT_CYC-1 with ack_s==0, the block SHALL set tx_req <= 0, state <= REQ_LO and pulse timeout_err for one cycle. done SHALL NOT pulse for the aborted transfer.
REQ-028 If ack_s==1 arrives in the same cycle the timeout is reached, the ack SHALL win: normal REQ_LO entry and no timeout_err.
REQ-029 The counter width SHALL be $clog2(TIMEOUT_CYC+1), with a minimum of 1. It SHALL never wrap, because it is cleared on every REQ_HI entry.
REQ-030 Minimum round trip with a zero-delay far side SHALL be 2*SYNC_STAGES+3 cycles from accept to the done pulse.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL set state=IDLE, tx_req=0, tx_data=0, all sync flops=0, counter=0, done=0 and timeout_err=0.
REQ-032 Reset asserted mid-transfer (REQ_HI or REQ_LO) SHALL drop tx_req on the next edge and abandon the transfer with no done and no timeout_err.
REQ-033 busy SHALL be 0 and in_ready SHALL be 1 in the first cycle after reset release, given ack_s==0.

Verification
REQ-034 Basic transfer: in_data=0xA5 accepted, with a far-side model returning ack 1 cycle after req and dropping it 1 cycle after req falls. Required: tx_data=0xA5 while tx_req=1, exactly one done pulse, then in_ready=1.
REQ-035 Back-to-back transfer: in_valid held high with 0x11 then 0x22. Required: the second accept occurs only after the first done, and the far side sees 0x11 then 0x22 with tx_data never changing while tx_req=1.
REQ-036 Timeout: TIMEOUT_CYC=16 with ack tied 0. Required: tx_req drops after 16 cycles in REQ_HI, one timeout_err pulse, no done, and in_ready=1 two cycles later.
REQ-037 Stale ack: ack held 1 in IDLE while in_valid=1. Required: in_ready=0 and no accept; after ack falls, accept follows SYNC_STAGES cycles later.
REQ-038 Reset mid-transfer: rst pulsed while in REQ_HI. Required: next cycle has tx_req=0, tx_data=0 and state IDLE, with no done or timeout_err.
REQ-039 Ack/timeout collision: ack_s rises in the exact cycle the counter hits its limit. Required: done is later pulsed and timeout_err stays 0.
